// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: command byte codes and
// the sequencer state encoding.
package acq_pkg;

    localparam logic [7:0] CMD_START_SINGLE = 8'h01;
    localparam logic [7:0] CMD_START_TRIG   = 8'h02;
    localparam logic [7:0] CMD_STOP         = 8'h03;
    localparam logic [7:0] CMD_CLR_ERR      = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TRIG = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_COUNT     = 3'd3,
        ST_LATCH     = 3'd4,
        ST_HOLD      = 3'd5
    } acq_state_t;

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered
// rising-edge detector; pulse is one clock wide, three clocks after the pin.
module trig_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    // sync[1:0] is the metastability chain, sync[2] holds the previous level.
    logic [2:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], async_in};
            pulse <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Per-pattern photon-count acquisition sequencer: clear, settle, gated count
// window, latch, then hand the result to the SPI readout.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int WIN_W         = 24,
    parameter int IDX_W         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       COMMAND,
    input  logic             CMD_VALID,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic             DMD_TRIG,
    input  logic [CNT_W-1:0] COUNT_IN,
    output logic             START_COUNT,
    output logic             CLEAR_COUNT,
    output logic [CNT_W-1:0] RESULT,
    output logic [IDX_W-1:0] RESULT_IDX,
    output logic             RESULT_VALID,
    input  logic             RESULT_READY,
    output logic             BUSY,
    output logic             OVERRUN,
    output logic [2:0]       DBG_STATE
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

    acq_state_t       state;
    acq_state_t       state_next;
    logic             trig_mode;
    logic             trig_pulse;
    logic [SCW-1:0]   settle_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [IDX_W-1:0] idx;

    logic cmd_start_single;
    logic cmd_start_trig;
    logic cmd_stop;
    logic cmd_clr_err;
    logic enter_settle;
    logic trig_lost;

    trig_sync_edge u_trig_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (DMD_TRIG),
        .pulse    (trig_pulse)
    );

    assign cmd_start_single = CMD_VALID && (COMMAND == CMD_START_SINGLE);
    assign cmd_start_trig   = CMD_VALID && (COMMAND == CMD_START_TRIG);
    assign cmd_stop         = CMD_VALID && (COMMAND == CMD_STOP);
    assign cmd_clr_err      = CMD_VALID && (COMMAND == CMD_CLR_ERR);

    assign enter_settle = (state_next == ST_SETTLE) && (state != ST_SETTLE);
    assign trig_lost    = trig_pulse && trig_mode &&
                          (state inside {ST_SETTLE, ST_COUNT, ST_LATCH, ST_HOLD});

    // Gate and clear are pure decodes of the state register, so an async
    // reset drops them in the same instant the state returns to IDLE.
    assign START_COUNT = (state == ST_COUNT);
    assign CLEAR_COUNT = (state == ST_SETTLE) && (settle_cnt == '0);
    assign DBG_STATE   = state;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_start_single)    state_next = ST_SETTLE;
                else if (cmd_start_trig) state_next = ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
                if (cmd_stop)            state_next = ST_IDLE;
                else if (trig_pulse)     state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cmd_stop)                       state_next = ST_IDLE;
                else if (settle_cnt == SETTLE_LAST) state_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (cmd_stop)                       state_next = ST_IDLE;
                else if (win_cnt == WIN_W'(1))      state_next = ST_LATCH;
            end
            ST_LATCH: state_next = ST_HOLD;
            // RESULT_VALID/RESULT/RESULT_IDX are held while in HOLD; a transfer
            // happens on any cycle with RESULT_VALID and RESULT_READY both high.
            ST_HOLD: begin
                if (RESULT_READY)
                    state_next = (trig_mode && !cmd_stop) ? ST_WAIT_TRIG : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            trig_mode    <= 1'b0;
            settle_cnt   <= '0;
            win_cnt      <= '0;
            idx          <= '0;
            RESULT       <= '0;
            RESULT_IDX   <= '0;
            RESULT_VALID <= 1'b0;
            OVERRUN      <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            state <= state_next;
            BUSY  <= (state_next != ST_IDLE);

            if (cmd_stop)
                trig_mode <= 1'b0;
            else if (state == ST_IDLE && cmd_start_single)
                trig_mode <= 1'b0;
            else if (state == ST_IDLE && cmd_start_trig)
                trig_mode <= 1'b1;

            // A zero window would never close the gate, so it runs as one cycle.
            if (enter_settle) begin
                settle_cnt <= '0;
                win_cnt    <= (WINDOW == '0) ? WIN_W'(1) : WINDOW;
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else if (state == ST_COUNT) begin
                win_cnt <= win_cnt - 1'b1;
            end

            if (state == ST_IDLE && (cmd_start_single || cmd_start_trig)) begin
                idx <= '0;
            end else if (state == ST_LATCH) begin
                RESULT       <= COUNT_IN;
                RESULT_IDX   <= idx;
                RESULT_VALID <= 1'b1;
                idx          <= idx + 1'b1;
            end else if (state == ST_HOLD && RESULT_READY) begin
                RESULT_VALID <= 1'b0;
            end

            if (trig_lost)
                OVERRUN <= 1'b1;
            else if (cmd_clr_err)
                OVERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: directed scenarios plus randomized windows, ready
// back-pressure and trigger spacing, checked against a timeline model.
module tb_acq_sequencer;
    import acq_pkg::*;

    localparam int CNT_W  = 32;
    localparam int WIN_W  = 24;
    localparam int IDX_W  = 16;
    localparam int SETTLE = 4;
    localparam int HIST   = 16384;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [7:0]       COMMAND = '0;
    logic             CMD_VALID = 1'b0;
    logic [WIN_W-1:0] WINDOW = '0;
    logic             DMD_TRIG = 1'b0;
    logic [CNT_W-1:0] COUNT_IN = '0;
    logic             START_COUNT;
    logic             CLEAR_COUNT;
    logic [CNT_W-1:0] RESULT;
    logic [IDX_W-1:0] RESULT_IDX;
    logic             RESULT_VALID;
    logic             RESULT_READY = 1'b0;
    logic             BUSY;
    logic             OVERRUN;
    logic [2:0]       DBG_STATE;

    acq_sequencer #(
        .CNT_W(CNT_W), .WIN_W(WIN_W), .IDX_W(IDX_W), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .CLK(CLK), .RST(RST), .COMMAND(COMMAND), .CMD_VALID(CMD_VALID),
        .WINDOW(WINDOW), .DMD_TRIG(DMD_TRIG), .COUNT_IN(COUNT_IN),
        .START_COUNT(START_COUNT), .CLEAR_COUNT(CLEAR_COUNT), .RESULT(RESULT),
        .RESULT_IDX(RESULT_IDX), .RESULT_VALID(RESULT_VALID),
        .RESULT_READY(RESULT_READY), .BUSY(BUSY), .OVERRUN(OVERRUN),
        .DBG_STATE(DBG_STATE)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int acc_exp = 0;
    int cyc = 0;
    logic [CNT_W-1:0] cin_hist [HIST];
    int clr_q[$];
    int gate_q[$];
    logic [IDX_W+31:0] exp_q[$];
    logic [IDX_W+31:0] e_mon;
    bit   rdy_rand = 1'b0;
    logic rdy_fixed = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [CNT_W-1:0] prev_res = '0;
    logic [IDX_W-1:0] prev_idx = '0;

    // clock
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        COUNT_IN = $urandom;
        cin_hist[cyc % HIST] = COUNT_IN;
        RESULT_READY = rdy_rand ? ($urandom_range(0, 2) == 0) : rdy_fixed;
    endtask

    task automatic send_cmd(input logic [7:0] c, output int t);
        COMMAND   = c;
        CMD_VALID = 1'b1;
        t = cyc;
        tick();
        CMD_VALID = 1'b0;
        COMMAND   = '0;
    endtask

    task automatic pulse_trig(output int tp);
        DMD_TRIG = 1'b1;
        tp = cyc;
        repeat (3) tick();
        DMD_TRIG = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (DBG_STATE !== st && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " reach_state"}, DBG_STATE, st);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (RESULT_VALID !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " valid_seen"}, RESULT_VALID, 1);
    endtask

    // Reference model: an acquisition whose clear cycle is s gates cycles
    // s+SETTLE .. s+SETTLE+w-1 and latches COUNT_IN of the following cycle.
    task automatic expect_acq(input int k, input int s, input int w);
        int weff = (w == 0) ? 1 : w;
        logic [31:0] kk = k;
        exp_q.push_back({kk[IDX_W-1:0], 32'(s + SETTLE + weff)});
        acc_exp++;
    endtask

    task automatic check_acq(input int s, input int w, input string tag);
        int weff = (w == 0) ? 1 : w;
        chk({tag, " clr_n"}, clr_q.size(), 1);
        if (clr_q.size() > 0) chk({tag, " clr_cyc"}, clr_q[0], s);
        chk({tag, " gate_n"}, gate_q.size(), weff);
        if (gate_q.size() > 0) begin
            chk({tag, " gate_first"}, gate_q[0], s + SETTLE);
            chk({tag, " gate_last"}, gate_q[gate_q.size()-1], s + SETTLE + weff - 1);
        end
        clr_q.delete();
        gate_q.delete();
    endtask

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge CLK) begin
        if (RST) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (CLEAR_COUNT) clr_q.push_back(cyc);
            if (START_COUNT) gate_q.push_back(cyc);
            if (RESULT_VALID && !prev_valid) begin
                if (exp_q.size() == 0) chk("spurious_result_valid", RESULT_VALID, 0);
                else chk("valid_rise_cyc", cyc, exp_q[0][31:0] + 1);
            end
            if (prev_valid && !prev_ready) begin
                chk("valid_held", RESULT_VALID, 1);
                chk("result_stable", RESULT, prev_res);
                chk("idx_stable", RESULT_IDX, prev_idx);
            end
            if (RESULT_VALID && RESULT_READY && exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                chk("result_idx", RESULT_IDX, e_mon[IDX_W+31:32]);
                chk("result_val", RESULT, cin_hist[e_mon[31:0] % HIST]);
                n_acc++;
            end
            prev_valid = RESULT_VALID;
            prev_ready = RESULT_READY;
            prev_res   = RESULT;
            prev_idx   = RESULT_IDX;
        end
    end

    initial begin
        int t0, s, tp, c, w, acc0;

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst start_count", START_COUNT, 0);
        chk("rst clear_count", CLEAR_COUNT, 0);
        chk("rst result", RESULT, 0);
        chk("rst result_idx", RESULT_IDX, 0);
        chk("rst result_valid", RESULT_VALID, 0);
        chk("rst busy", BUSY, 0);
        chk("rst overrun", OVERRUN, 0);
        chk("rst state", DBG_STATE, ST_IDLE);
        RST = 1'b0;
        tick();

        // single acquisition, window 10, ready held low for a while
        rdy_fixed = 1'b0;
        WINDOW = 10;
        send_cmd(CMD_START_SINGLE, t0);
        s = t0 + 1;
        expect_acq(0, s, 10);
        chk("t1 busy", BUSY, 1);
        wait_valid(40, "t1");
        repeat (5) tick();
        chk("t1 valid_waiting", RESULT_VALID, 1);
        rdy_fixed = 1'b1;
        wait_state(ST_IDLE, 10, "t1");
        check_acq(s, 10, "t1");
        chk("t1 n_acc", n_acc, 1);
        chk("t1 busy_low", BUSY, 0);
        chk("t1 valid_low", RESULT_VALID, 0);

        // triggered mode, three triggers 50 cycles apart
        WINDOW = 20;
        acc0 = n_acc;
        send_cmd(CMD_START_TRIG, t0);
        for (int k = 0; k < 3; k++) begin
            pulse_trig(tp);
            expect_acq(k, tp + 4, 20);
            run_to(tp + 45);
            check_acq(tp + 4, 20, "t2");
            run_to(tp + 50);
        end
        chk("t2 n_acc", n_acc - acc0, 3);
        chk("t2 overrun", OVERRUN, 0);
        chk("t2 state", DBG_STATE, ST_WAIT_TRIG);
        send_cmd(CMD_STOP, t0);
        wait_state(ST_IDLE, 5, "t2 stop");

        // second trigger lands during COUNT
        acc0 = n_acc;
        send_cmd(CMD_START_TRIG, t0);
        pulse_trig(tp);
        expect_acq(0, tp + 4, 20);
        run_to(tp + 15);
        pulse_trig(c);
        run_to(tp + 60);
        check_acq(tp + 4, 20, "t3");
        chk("t3 n_acc", n_acc - acc0, 1);
        chk("t3 overrun_set", OVERRUN, 1);
        send_cmd(CMD_CLR_ERR, t0);
        chk("t3 overrun_clr", OVERRUN, 0);
        send_cmd(CMD_STOP, t0);
        wait_state(ST_IDLE, 5, "t3 stop");

        // STOP in the middle of the count window
        send_cmd(CMD_START_SINGLE, t0);
        s = t0 + 1;
        run_to(s + 10);
        c = cyc;
        send_cmd(CMD_STOP, t0);
        chk("t4 gate_off", START_COUNT, 0);
        chk("t4 state", DBG_STATE, ST_IDLE);
        repeat (30) tick();
        chk("t4 no_valid", RESULT_VALID, 0);
        chk("t4 busy", BUSY, 0);
        chk("t4 clr_n", clr_q.size(), 1);
        chk("t4 gate_n", gate_q.size(), c - (s + SETTLE) + 1);
        if (gate_q.size() > 0) chk("t4 gate_last", gate_q[gate_q.size()-1], c);
        clr_q.delete();
        gate_q.delete();

        // STOP while holding a result with ready low for 8 cycles
        rdy_fixed = 1'b0;
        WINDOW = 5;
        send_cmd(CMD_START_TRIG, t0);
        pulse_trig(tp);
        expect_acq(0, tp + 4, 5);
        wait_valid(40, "t5");
        send_cmd(CMD_STOP, t0);
        repeat (6) tick();
        chk("t5 valid_kept", RESULT_VALID, 1);
        chk("t5 state", DBG_STATE, ST_HOLD);
        rdy_fixed = 1'b1;
        wait_state(ST_IDLE, 5, "t5");
        check_acq(tp + 4, 5, "t5");
        pulse_trig(tp);
        repeat (30) tick();
        chk("t5 no_rearm", clr_q.size(), 0);
        chk("t5 busy", BUSY, 0);
        chk("t5 overrun", OVERRUN, 0);

        // zero window runs one gate cycle
        WINDOW = 0;
        send_cmd(CMD_START_SINGLE, t0);
        expect_acq(0, t0 + 1, 0);
        run_to(t0 + 20);
        check_acq(t0 + 1, 0, "t6");

        // commands ignored while busy and unknown opcodes
        WINDOW = 10;
        send_cmd(CMD_START_SINGLE, t0);
        s = t0 + 1;
        expect_acq(0, s, 10);
        send_cmd(CMD_START_SINGLE, c);
        send_cmd(CMD_START_TRIG, c);
        WINDOW = 3;
        run_to(t0 + 30);
        check_acq(s, 10, "t7");
        chk("t7 state", DBG_STATE, ST_IDLE);
        pulse_trig(tp);
        repeat (20) tick();
        chk("t7 trig_ignored", clr_q.size(), 0);
        send_cmd(8'h55, c);
        repeat (3) tick();
        chk("t7 busy_55", BUSY, 0);
        chk("t7 clr_55", clr_q.size(), 0);

        // asynchronous reset during COUNT with OVERRUN set
        WINDOW = 30;
        send_cmd(CMD_START_TRIG, t0);
        pulse_trig(tp);
        run_to(tp + 15);
        pulse_trig(c);
        run_to(tp + 21);
        chk("t8 pre_gate", START_COUNT, 1);
        chk("t8 pre_overrun", OVERRUN, 1);
        #3;
        RST = 1'b1;
        #1;
        chk("t8 gate", START_COUNT, 0);
        chk("t8 clear", CLEAR_COUNT, 0);
        chk("t8 result", RESULT, 0);
        chk("t8 valid", RESULT_VALID, 0);
        chk("t8 busy", BUSY, 0);
        chk("t8 overrun", OVERRUN, 0);
        chk("t8 state", DBG_STATE, ST_IDLE);
        tick();
        RST = 1'b0;
        clr_q.delete();
        gate_q.delete();
        repeat (40) tick();
        chk("t8 no_result", RESULT_VALID, 0);

        // randomized single acquisitions with random ready
        rdy_rand = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(0, 12);
            WINDOW = w;
            send_cmd(CMD_START_SINGLE, t0);
            expect_acq(0, t0 + 1, w);
            wait_state(ST_IDLE, 120, "rnd_single");
            check_acq(t0 + 1, w, "rnd_single");
        end

        // randomized triggered batch
        send_cmd(CMD_START_TRIG, t0);
        for (int k = 0; k < 5; k++) begin
            w = $urandom_range(0, 12);
            WINDOW = w;
            repeat ($urandom_range(0, 4)) tick();
            pulse_trig(tp);
            expect_acq(k, tp + 4, w);
            run_to(tp + 5);
            wait_state(ST_WAIT_TRIG, 120, "rnd_trig");
            check_acq(tp + 4, w, "rnd_trig");
        end
        chk("rnd overrun", OVERRUN, 0);
        send_cmd(CMD_STOP, t0);
        wait_state(ST_IDLE, 5, "rnd stop");
        repeat (5) tick();

        // final report
        chk("total accepted", n_acc, acc_exp);
        chk("pending expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
